// File: rtl/floatmul_pipe.sv
// floatmul_pipe: 3-stage pipelined floating-point multiplier with
// round-to-nearest-even and flush-to-zero for subnormal inputs and results.
// Operand A and operand B arrive on two valid/ready streams. A pair is
// consumed only when both operands are present. Results leave in order on a
// valid/ready output stream.
//
// Optional build macro: FLOATMUL_PIPE_FLAGS_EN adds the o_flags port
// {invalid, overflow, underflow, inexact}, carried through the pipeline
// alongside the payload.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous reset, active low
//   busy       any pipeline stage holds a valid entry
//   a_valid    operand A valid        a_payload  operand A {sign,exp,frac}
//   a_ready    operand A accepted     (a_valid & a_ready)
//   b_valid    operand B valid        b_payload  operand B
//   b_ready    operand B accepted
//   o_valid    result valid           o_payload  result
//   o_ready    result consumer ready
//   o_flags    exception flags (FLOATMUL_PIPE_FLAGS_EN only)
module floatmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   busy,
  input  logic                   a_valid,
  input  logic [EXP_W+MAN_W:0]   a_payload,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [EXP_W+MAN_W:0]   b_payload,
  output logic                   b_ready,
  output logic                   o_valid,
  output logic [EXP_W+MAN_W:0]   o_payload,
  input  logic                   o_ready
`ifdef FLOATMUL_PIPE_FLAGS_EN
  ,
  output logic [3:0]             o_flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Unpack operands
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sa = a_payload[W-1];
  assign sb = b_payload[W-1];
  assign ea = a_payload[W-2:MAN_W];
  assign eb = b_payload[W-2:MAN_W];
  assign fa = a_payload[MAN_W-1:0];
  assign fb = b_payload[MAN_W-1:0];

  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  // Pipeline registers
  logic             s1_v_q, s2_v_q, s3_v_q;
  logic             s1_sign_q, s2_sign_q;
  logic [XW-1:0]    s1_exp_q, s2_exp_q;
  logic [PW-1:0]    s1_prod_q;
  logic             s1_spec_q, s2_spec_q;
  logic [W-1:0]     s1_spec_res_q, s2_spec_res_q;
  logic [MAN_W-1:0] s2_frac_q;
  logic             s2_guard_q, s2_sticky_q;
  logic [W-1:0]     s3_res_q;
`ifdef FLOATMUL_PIPE_FLAGS_EN
  logic             s1_inv_q, s2_inv_q, s1_inv_d;
  logic [3:0]       s3_flags_q, s3_flags_d;
`endif

  // Handshake: a stage may load when it is empty or its contents move on
  logic s1_free, s2_free, s3_free, accept;

  assign s3_free = ~s3_v_q | o_ready;
  assign s2_free = ~s2_v_q | s3_free;
  assign s1_free = ~s1_v_q | s2_free;
  assign accept  = a_valid & b_valid & s1_free;
  assign a_ready = b_valid & s1_free;
  assign b_ready = a_valid & s1_free;

  // S1: special-case detection and mantissa product
  logic          s1_sign_d, s1_spec_d;
  logic [W-1:0]  s1_spec_res_d;
  logic [XW-1:0] s1_exp_d;
  logic [PW-1:0] s1_prod_d;

  assign s1_sign_d = sa ^ sb;
  assign s1_exp_d  = {2'b00, ea} + {2'b00, eb} - BIAS;
  assign s1_prod_d = PW'({1'b1, fa}) * PW'({1'b1, fb});

  always_comb begin
    s1_spec_d     = 1'b1;
    s1_spec_res_d = QNAN;
`ifdef FLOATMUL_PIPE_FLAGS_EN
    s1_inv_d      = 1'b0;
`endif
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
`ifdef FLOATMUL_PIPE_FLAGS_EN
      s1_inv_d = 1'b1;
`endif
    end else if (a_inf || b_inf) begin
      s1_spec_res_d = {s1_sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      s1_spec_res_d = {s1_sign_d, {(W-1){1'b0}}};
    end else begin
      s1_spec_d = 1'b0;
    end
  end

  // S2: normalise so the leading one sits just above the fraction field;
  // the bit shifted out on a top-bit product folds into sticky.
  logic [MAN_W-1:0] s2_frac_d;
  logic             s2_guard_d, s2_sticky_d;
  logic [XW-1:0]    s2_exp_d;

  always_comb begin
    if (s1_prod_q[PW-1]) begin
      s2_frac_d   = s1_prod_q[PW-2 -: MAN_W];
      s2_guard_d  = s1_prod_q[PW-2-MAN_W];
      s2_sticky_d = |s1_prod_q[PW-3-MAN_W:0];
      s2_exp_d    = s1_exp_q + {{(XW-1){1'b0}}, 1'b1};
    end else begin
      s2_frac_d   = s1_prod_q[PW-3 -: MAN_W];
      s2_guard_d  = s1_prod_q[PW-3-MAN_W];
      s2_sticky_d = |s1_prod_q[PW-4-MAN_W:0];
      s2_exp_d    = s1_exp_q;
    end
  end

  // S3: round to nearest even, range check, pack
  logic           round_up, ovf, unf;
  logic [MAN_W:0] mant_r;
  logic [XW-1:0]  exp_f;
  logic [W-1:0]   s3_res_d;

  assign round_up = s2_guard_q & (s2_frac_q[0] | s2_sticky_q);
  assign mant_r   = {1'b0, s2_frac_q} + {{MAN_W{1'b0}}, round_up};
  // A rounding carry leaves the fraction at zero, only the exponent moves
  assign exp_f    = s2_exp_q + {{(XW-1){1'b0}}, mant_r[MAN_W]};
  assign ovf      = ~exp_f[XW-1] & (exp_f >= EXP_MAX);
  assign unf      = exp_f[XW-1] | (exp_f == '0);

  always_comb begin
    if (s2_spec_q)
      s3_res_d = s2_spec_res_q;
    else if (ovf)
      s3_res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf)
      s3_res_d = {s2_sign_q, {(W-1){1'b0}}};
    else
      s3_res_d = {s2_sign_q, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
  end

`ifdef FLOATMUL_PIPE_FLAGS_EN
  always_comb begin
    if (s2_spec_q)
      s3_flags_d = {s2_inv_q, 3'b000};
    else
      s3_flags_d = {1'b0, ovf, unf, s2_guard_q | s2_sticky_q | ovf | unf};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      s3_res_q   <= '0;
`ifdef FLOATMUL_PIPE_FLAGS_EN
      s3_flags_q <= 4'b0;
`endif
    end else begin
      if (s1_free) begin
        s1_v_q <= accept;
        if (accept) begin
          s1_sign_q     <= s1_sign_d;
          s1_exp_q      <= s1_exp_d;
          s1_prod_q     <= s1_prod_d;
          s1_spec_q     <= s1_spec_d;
          s1_spec_res_q <= s1_spec_res_d;
`ifdef FLOATMUL_PIPE_FLAGS_EN
          s1_inv_q      <= s1_inv_d;
`endif
        end
      end
      if (s2_free) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_sign_q     <= s1_sign_q;
          s2_exp_q      <= s2_exp_d;
          s2_frac_q     <= s2_frac_d;
          s2_guard_q    <= s2_guard_d;
          s2_sticky_q   <= s2_sticky_d;
          s2_spec_q     <= s1_spec_q;
          s2_spec_res_q <= s1_spec_res_q;
`ifdef FLOATMUL_PIPE_FLAGS_EN
          s2_inv_q      <= s1_inv_q;
`endif
        end
      end
      if (s3_free) begin
        s3_v_q <= s2_v_q;
        if (s2_v_q) begin
          s3_res_q   <= s3_res_d;
`ifdef FLOATMUL_PIPE_FLAGS_EN
          s3_flags_q <= s3_flags_d;
`endif
        end
      end
    end
  end

  assign o_valid   = s3_v_q;
  assign o_payload = s3_res_q;
  assign busy      = s1_v_q | s2_v_q | s3_v_q;
`ifdef FLOATMUL_PIPE_FLAGS_EN
  assign o_flags   = s3_flags_q;
`endif

endmodule

// File: tb/tb_floatmul_pipe.sv
// Testbench for floatmul_pipe (default float32 parameters). Expected results
// come from a hand-derived vector table and are queued on accept, then
// matched in order against what the DUT emits. Flag checks apply when built
// with FLOATMUL_PIPE_FLAGS_EN.
module tb_floatmul_pipe;

  typedef struct packed {
    logic [31:0] p;
    logic [3:0]  f;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [31:0] a_payload, b_payload;
  logic        o_valid, o_ready;
  logic [31:0] o_payload;
  logic [3:0]  flg_w;
`ifdef FLOATMUL_PIPE_FLAGS_EN
  logic [3:0]  o_flags;
  assign flg_w = o_flags;
`else
  assign flg_w = 4'b0;
`endif

  floatmul_pipe dut (
    .clk(clk), .rst(rst), .busy(busy),
    .a_valid(a_valid), .a_payload(a_payload), .a_ready(a_ready),
    .b_valid(b_valid), .b_payload(b_payload), .b_ready(b_ready),
    .o_valid(o_valid), .o_payload(o_payload), .o_ready(o_ready)
`ifdef FLOATMUL_PIPE_FLAGS_EN
    , .o_flags(o_flags)
`endif
  );

  always #5 clk = ~clk;

  // Vector table: a, b, result, flags {invalid,overflow,underflow,inexact}
  logic [31:0] va [0:16] = '{32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h7F000000,
                             32'h00800000, 32'h3F800001, 32'h3F800003, 32'h3F800005,
                             32'h3F800001, 32'h3FFFFFFF, 32'hC0400000, 32'h7FC00001,
                             32'hFFC00000, 32'h00000001, 32'h00000001, 32'h80000000,
                             32'h3F800000};
  logic [31:0] vb [0:16] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h7F000000,
                             32'h3F000000, 32'h3F800001, 32'h3FC00000, 32'h3FC00000,
                             32'h3FFFFFFE, 32'h3FFFFFFF, 32'h3F000000, 32'h3F800000,
                             32'h7F800000, 32'h7F800000, 32'h40000000, 32'h40A00000,
                             32'h3F800000};
  logic [31:0] vr [0:16] = '{32'h40400000, 32'h7FC00000, 32'hFF800000, 32'h7F800000,
                             32'h00000000, 32'h3F800002, 32'h3FC00004, 32'h3FC00008,
                             32'h40000000, 32'h407FFFFE, 32'hBFC00000, 32'h7FC00000,
                             32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h80000000,
                             32'h3F800000};
  logic [3:0]  vf [0:16] = '{4'h0, 4'h8, 4'h0, 4'h5, 4'h3, 4'h1, 4'h1, 4'h1,
                             4'h1, 4'h1, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0,
                             4'h0};

  res_t exp_q[$];
  res_t obs_q[$];
  res_t cur_exp;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Advance one clock; records handshakes seen in the cycle just ending
  task automatic tick(output bit acc);
    #1;
    acc = rst && a_valid && a_ready && b_valid && b_ready;
    if (acc) exp_q.push_back(cur_exp);
    if (rst && o_valid && o_ready) obs_q.push_back({o_payload, flg_w});
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int idx);
    a_payload = va[idx];
    b_payload = vb[idx];
    cur_exp   = {vr[idx], vf[idx]};
  endtask

  // Offer one pair until accepted (bounded)
  task automatic send(input int idx, output bit ok);
    bit acc;
    ok = 1'b0;
    set_vec(idx);
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(acc);
      ok = acc;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    a_valid = 1'b0;
    b_valid = 1'b0;
    o_ready = 1'b1;
    for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) tick(acc);
    for (int i = 0; i < 3; i++) tick(acc);
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; o_ready = 1'b1;
    a_payload = '0; b_payload = '0; cur_exp = '0;
    tick(acc); tick(acc);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b expected 0", o_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
`ifdef FLOATMUL_PIPE_FLAGS_EN
    n_checks++; if (o_flags !== 4'h0) $display("FAIL reset_flags: got %h expected 0", o_flags); else n_pass++;
`endif
    rst = 1'b1;
    tick(acc);
    b_valid = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL join_ready: got a_ready=%b b_ready=%b expected 1 0", a_ready, b_ready); else n_pass++;
    b_valid = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b0) $display("FAIL idle_a_ready: got %b expected 0", a_ready); else n_pass++;
  endtask

  task automatic test_latency();
    bit acc;
    res_t e, o;
    o_ready = 1'b1;
    set_vec(0);
    a_valid = 1'b1; b_valid = 1'b1;
    tick(acc);
    a_valid = 1'b0; b_valid = 1'b0;
    n_checks++; if (acc !== 1'b1) $display("FAIL latency_accept: got %b expected 1", acc); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL latency_n1: got %b expected 0", o_valid); else n_pass++;
    tick(acc);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL latency_n2: got %b expected 0", o_valid); else n_pass++;
    tick(acc);
    n_checks++; if (o_valid !== 1'b1 || o_payload !== 32'h40400000)
      $display("FAIL latency_n3: got valid=%b payload=%h expected 1 40400000", o_valid, o_payload); else n_pass++;
    drain();
    n_checks++; if (busy !== 1'b0) $display("FAIL latency_idle_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size())
      $display("FAIL latency_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o.p !== e.p) $display("FAIL latency_payload: got %h expected %h", o.p, e.p); else n_pass++;
`ifdef FLOATMUL_PIPE_FLAGS_EN
      n_checks++; if (o.f !== e.f) $display("FAIL latency_flags: got %h expected %h", o.f, e.f); else n_pass++;
`endif
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Specials, overflow/underflow and rounding, issued back-to-back
  task automatic test_arith();
    bit ok;
    int n_ok = 0;
    res_t e, o;
    o_ready = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      send(k, ok);
      if (ok) n_ok++;
    end
    drain();
    n_checks++; if (n_ok != 16) $display("FAIL arith_accepts: got %0d expected 16", n_ok); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size())
      $display("FAIL arith_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o.p !== e.p) $display("FAIL arith_payload: got %h expected %h", o.p, e.p); else n_pass++;
`ifdef FLOATMUL_PIPE_FLAGS_EN
      n_checks++; if (o.f !== e.f) $display("FAIL arith_flags: result %h got %h expected %h", e.p, o.f, e.f); else n_pass++;
`endif
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_no_accept();
    bit acc;
    set_vec(0);
    a_valid = 1'b1; b_valid = 1'b0; o_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1)
        $display("FAIL lone_a_ready: got a_ready=%b b_ready=%b expected 0 1", a_ready, b_ready); else n_pass++;
      tick(acc);
      n_checks++; if (acc !== 1'b0 || busy !== 1'b0)
        $display("FAIL lone_a_accept: got acc=%b busy=%b expected 0 0", acc, busy); else n_pass++;
    end
    a_valid = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL lone_a_queue: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit acc, have;
    int idx = 0;
    int list [0:4] = '{0, 5, 10, 16, 9};
    logic [31:0] held;
    res_t e, o;
    have = 1'b0; held = '0;
    o_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_vec(list[idx]);
      a_valid = 1'b1; b_valid = 1'b1;
      tick(acc);
      if (acc) idx++;
      if (o_valid) begin
        if (!have) begin
          have = 1'b1; held = o_payload;
        end else begin
          n_checks++; if (o_payload !== held) $display("FAIL stall_hold: got %h expected %h", o_payload, held); else n_pass++;
        end
      end
    end
    n_checks++; if (idx != 3) $display("FAIL stall_accepts: got %0d expected 3", idx); else n_pass++;
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL stall_full: got a_ready=%b b_ready=%b busy=%b expected 0 0 1", a_ready, b_ready, busy); else n_pass++;
    n_checks++; if (o_valid !== 1'b1 || held !== vr[0])
      $display("FAIL stall_head: got valid=%b payload=%h expected 1 %h", o_valid, held, vr[0]); else n_pass++;
    o_ready = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1)
      $display("FAIL full_release_ready: got a_ready=%b b_ready=%b expected 1 1", a_ready, b_ready); else n_pass++;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      set_vec(list[idx]);
      a_valid = 1'b1; b_valid = 1'b1;
      tick(acc);
      if (acc) idx++;
    end
    drain();
    n_checks++; if (obs_q.size() != 5) $display("FAIL b2b_count: got %0d expected 5", obs_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o.p !== e.p) $display("FAIL b2b_order: got %h expected %h", o.p, e.p); else n_pass++;
`ifdef FLOATMUL_PIPE_FLAGS_EN
      n_checks++; if (o.f !== e.f) $display("FAIL b2b_flags: got %h expected %h", o.f, e.f); else n_pass++;
`endif
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_in_flight();
    bit acc, ok;
    res_t e, o;
    o_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send(k, ok);
    n_checks++; if (busy !== 1'b1 || exp_q.size() != 3)
      $display("FAIL flight_setup: got busy=%b queued=%0d expected 1 3", busy, exp_q.size()); else n_pass++;
    rst = 1'b0;
    tick(acc);
    rst = 1'b1;
    exp_q.delete();
    n_checks++; if (o_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL flight_reset: got valid=%b busy=%b expected 0 0", o_valid, busy); else n_pass++;
`ifdef FLOATMUL_PIPE_FLAGS_EN
    n_checks++; if (o_flags !== 4'h0) $display("FAIL flight_flags: got %h expected 0", o_flags); else n_pass++;
`endif
    o_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(acc);
      n_checks++; if (o_valid !== 1'b0) $display("FAIL flight_stale: got %b expected 0", o_valid); else n_pass++;
    end
    send(16, ok);
    drain();
    n_checks++; if (obs_q.size() != 1) $display("FAIL flight_after_count: got %0d expected 1", obs_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o.p !== e.p) $display("FAIL flight_after: got %h expected %h", o.p, e.p); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random_flow();
    bit acc, pending, a_arr, b_arr, prev_stall;
    int sent = 0;
    logic [31:0] prev_p;
    res_t e, o;
    pending = 1'b0; a_arr = 1'b0; b_arr = 1'b0; prev_stall = 1'b0; prev_p = '0;
    for (int c = 0; c < 600 && sent < 20; c++) begin
      if (!pending) begin
        set_vec($urandom_range(0, 16));
        pending = 1'b1; a_arr = 1'b0; b_arr = 1'b0;
      end
      if (!a_arr) a_arr = 1'($urandom_range(0, 1));
      if (!b_arr) b_arr = 1'($urandom_range(0, 1));
      a_valid = a_arr; b_valid = b_arr;
      o_ready = ($urandom_range(0, 3) != 0);
      if (prev_stall) begin
        n_checks++; if (o_valid !== 1'b1 || o_payload !== prev_p)
          $display("FAIL rand_hold: got valid=%b payload=%h expected 1 %h", o_valid, o_payload, prev_p); else n_pass++;
      end
      prev_stall = o_valid && !o_ready;
      prev_p = o_payload;
      tick(acc);
      if (acc) begin sent++; pending = 1'b0; end
    end
    drain();
    n_checks++; if (sent != 20) $display("FAIL rand_sent: got %0d expected 20", sent); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size())
      $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o.p !== e.p) $display("FAIL rand_payload: got %h expected %h", o.p, e.p); else n_pass++;
`ifdef FLOATMUL_PIPE_FLAGS_EN
      n_checks++; if (o.f !== e.f) $display("FAIL rand_flags: got %h expected %h", o.f, e.f); else n_pass++;
`endif
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_no_accept();
    test_back_to_back();
    test_reset_in_flight();
    test_random_flow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
